note_sequencer: RTL and testbench



---
 rtl/note_sequencer.sv | 148 ++++++++++++++
 tb/tb_note_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - keypad pass-through, melody recorder and tick-exact player
// Define LOOP_PLAYBACK_EN to repeat playback until play_btn, rec_btn or rst.
module note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 1000000,
  parameter int DUR_W    = 8,
  parameter int CODE_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CODE_W-1:0]         key_code,
  input  logic                      rec_btn,
  input  logic                      play_btn,
  output logic [CODE_W-1:0]         note_out,
  output logic                      recording,
  output logic                      playing,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;
  state_t state, state_nxt;

  logic [CODE_W+DUR_W-1:0] mem [DEPTH];
  logic [TW-1:0]     tick_cnt, tick_cnt_nxt;
  logic [DUR_W-1:0]  dur, dur_nxt, dur_eff, rd_dur;
  logic [CODE_W-1:0] cur, cur_nxt, note_nxt;
  logic [AW-1:0]     idx, idx_nxt;
  logic [CW-1:0]     count_nxt;
  logic              full_nxt, tick, wr_en;

  assign tick      = (tick_cnt == TICK_LAST);
  // In REC the tick landing on a boundary cycle still counts toward that segment.
  assign dur_eff   = dur + DUR_W'(tick);
  assign rd_dur    = mem[idx][DUR_W-1:0];
  assign recording = (state == REC);
  assign playing   = (state == PLAY);

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
    dur_nxt      = dur;
    cur_nxt      = cur;
    note_nxt     = key_code;
    idx_nxt      = idx;
    count_nxt    = count;
    full_nxt     = full;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (rec_btn) begin
          state_nxt    = REC;
          count_nxt    = '0;
          full_nxt     = 1'b0;
          cur_nxt      = key_code;
          dur_nxt      = '0;
          tick_cnt_nxt = '0;
        end else if (play_btn && count != '0) begin
          state_nxt    = PLAY;
          idx_nxt      = '0;
          dur_nxt      = '0;
          tick_cnt_nxt = '0;
          note_nxt     = mem[0][CODE_W+DUR_W-1 -: CODE_W];
        end
      end
      REC: begin
        dur_nxt = dur_eff;
        if (rec_btn || key_code != cur || dur_eff == DUR_MAX) begin
          wr_en        = (dur_eff != '0);
          dur_nxt      = '0;
          tick_cnt_nxt = '0;
          cur_nxt      = key_code;
          if (rec_btn)
            state_nxt = IDLE;
          if (wr_en) begin
            count_nxt = count + 1'b1;
            if (count + 1'b1 == DEPTH_C) begin
              full_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      PLAY: begin
        note_nxt = note_out;
        if (rec_btn || play_btn) begin
          state_nxt = IDLE;
          note_nxt  = key_code;
        end else if (tick) begin
          // dur counts elapsed ticks of the current entry during playback
          if (dur + 1'b1 == rd_dur) begin
            dur_nxt = '0;
            if ({1'b0, idx} == count - 1'b1) begin
`ifdef LOOP_PLAYBACK_EN
              idx_nxt  = '0;
              note_nxt = mem[0][CODE_W+DUR_W-1 -: CODE_W];
`else
              state_nxt = IDLE;
              note_nxt  = key_code;
`endif
            end else begin
              idx_nxt  = idx + 1'b1;
              note_nxt = mem[idx + 1'b1][CODE_W+DUR_W-1 -: CODE_W];
            end
          end else begin
            dur_nxt = dur + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      dur      <= '0;
      cur      <= '0;
      note_out <= '0;
      idx      <= '0;
      count    <= '0;
      full     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      dur      <= dur_nxt;
      cur      <= cur_nxt;
      note_out <= note_nxt;
      idx      <= idx_nxt;
      count    <= count_nxt;
      full     <= full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[count[AW-1:0]] <= {cur, dur_eff};
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed and randomized record/playback checks for note_sequencer
module tb_note_sequencer;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 3;
  localparam int CODE_W   = 8;
  localparam int DUR_MAX  = (1 << DUR_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code = 8'h00;
  logic       rec_btn = 1'b0;
  logic       play_btn = 1'b0;
  logic [7:0] note_out;
  logic       recording, playing, full;
  logic [2:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] seg_code[$];
  int         seg_len[$];
  logic [7:0] exp_code[$];
  int         exp_dur[$];

  note_sequencer #(
    .DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W), .CODE_W(CODE_W)
  ) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .rec_btn(rec_btn), .play_btn(play_btn),
    .note_out(note_out), .recording(recording), .playing(playing), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Each held key yields floor(cycles/TICK_DIV) ticks, split into DUR_MAX-sized
  // entries; sub-tick segments vanish and the buffer stops at DEPTH entries.
  function automatic void build_model();
    exp_code.delete();
    exp_dur.delete();
    foreach (seg_len[i]) begin
      int t;
      t = seg_len[i] / TICK_DIV;
      while (t >= DUR_MAX && exp_code.size() < DEPTH) begin
        exp_code.push_back(seg_code[i]);
        exp_dur.push_back(DUR_MAX);
        t -= DUR_MAX;
      end
      if (t > 0 && exp_code.size() < DEPTH) begin
        exp_code.push_back(seg_code[i]);
        exp_dur.push_back(t);
      end
    end
  endfunction

  task automatic do_record();
    key_code = seg_code[0];
    rec_btn  = 1'b1;
    step(1);
    rec_btn  = 1'b0;
    chk("rec_active", recording, 1);
    chk("rec_monitor", note_out, seg_code[0]);
    for (int i = 0; i < seg_code.size(); i++) begin
      if (i > 0) key_code = seg_code[i];
      step(i == 0 ? seg_len[i] - 1 : seg_len[i]);
    end
    rec_btn = 1'b1;
    step(1);
    rec_btn = 1'b0;
    build_model();
    chk("rec_done", recording, 0);
    chk("rec_count", count, exp_code.size());
  endtask

  task automatic play_and_check();
    logic [7:0] kprev;
    kprev    = 8'($urandom);
    key_code = kprev;
    play_btn = 1'b1;
    step(1);
    play_btn = 1'b0;
    if (exp_code.size() == 0) begin
      chk("play_empty", playing, 0);
      chk("play_empty_note", note_out, kprev);
      return;
    end
    foreach (exp_code[k]) begin
      for (int d = 0; d < exp_dur[k] * TICK_DIV; d++) begin
        chk("play_active", playing, 1);
        chk("play_note", note_out, exp_code[k]);
        kprev    = 8'($urandom);
        key_code = kprev;
        step(1);
      end
    end
`ifdef LOOP_PLAYBACK_EN
    chk("loop_active", playing, 1);
    chk("loop_note", note_out, exp_code[0]);
    play_btn = 1'b1;
    kprev    = key_code;
    step(1);
    play_btn = 1'b0;
`endif
    chk("play_end", playing, 0);
    chk("play_end_note", note_out, kprev);
    chk("play_keep_count", count, exp_code.size());
  endtask

  initial begin
    step(2);
    chk("rst_note", note_out, 0);
    chk("rst_rec", recording, 0);
    chk("rst_play", playing, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    step(1);

    // empty buffer: play ignored
    key_code = 8'h33;
    play_btn = 1'b1;
    step(1);
    play_btn = 1'b0;
    chk("empty_play", playing, 0);
    chk("empty_rec", recording, 0);
    chk("idle_pass", note_out, 8'h33);

    // basic record and playback
    seg_code = '{8'h01, 8'h02};
    seg_len  = '{12, 8};
    do_record();
    chk("basic_count", count, 2);
    play_and_check();

    // asynchronous reset mid-play
    play_btn = 1'b1;
    step(1);
    play_btn = 1'b0;
    step(3);
    chk("pre_rst_play", playing, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_note", note_out, 0);
    chk("async_rst_play", playing, 0);
    chk("async_rst_count", count, 0);
    step(2);
    rst = 1'b0;
    key_code = 8'h05;
    step(1);
    chk("post_rst_pass", note_out, 8'h05);

    // glitch shorter than a tick creates no entry
    seg_code = '{8'h10, 8'h11, 8'h12};
    seg_len  = '{8, 2, 8};
    do_record();
    chk("glitch_count", count, 2);
    play_and_check();

    // buffer fills on the fourth commit and forces IDLE
    key_code = 8'h21; rec_btn = 1'b1; step(1); rec_btn = 1'b0;
    step(3);
    key_code = 8'h22; step(4);
    key_code = 8'h23; step(4);
    key_code = 8'h24; step(1);
    chk("prefull_count", count, 3);
    chk("prefull_full", full, 0);
    chk("prefull_rec", recording, 1);
    step(3);
    key_code = 8'h25; step(1);
    chk("full_flag", full, 1);
    chk("full_idle", recording, 0);
    chk("full_count", count, 4);
    key_code = 8'h26; step(6);
    chk("full_hold_count", count, 4);
    seg_code = '{8'h21, 8'h22, 8'h23, 8'h24};
    seg_len  = '{4, 4, 4, 4};
    build_model();
    play_and_check();
    chk("full_kept", full, 1);

    // long note splits at the duration limit
    seg_code = '{8'h03};
    seg_len  = '{9 * TICK_DIV};
    do_record();
    chk("sat_count", count, 2);
    play_and_check();

    // aborts by play_btn and rec_btn
    seg_code = '{8'h31, 8'h32};
    seg_len  = '{8, 8};
    do_record();
    play_btn = 1'b1; step(1); play_btn = 1'b0;
    step(3);
    chk("abort_pre", playing, 1);
    key_code = 8'h44;
    play_btn = 1'b1; step(1); play_btn = 1'b0;
    chk("abort_play", playing, 0);
    chk("abort_count", count, 2);
    chk("abort_note", note_out, 8'h44);
    play_btn = 1'b1; step(1); play_btn = 1'b0;
    step(2);
    rec_btn = 1'b1; step(1); rec_btn = 1'b0;
    chk("abort_rec_play", playing, 0);
    chk("abort_rec_norec", recording, 0);
    step(1);
    chk("abort_rec_idle", recording, 0);
    chk("abort_rec_count", count, 2);

    // rec_btn wins over play_btn in IDLE
    rec_btn = 1'b1; play_btn = 1'b1; step(1);
    rec_btn = 1'b0; play_btn = 1'b0;
    chk("both_rec", recording, 1);
    chk("both_play", playing, 0);
    step(2);
    rec_btn = 1'b1; step(1); rec_btn = 1'b0;
    chk("both_end", recording, 0);
    chk("both_count", count, 0);

    // randomized melodies
    for (int it = 0; it < 8; it++) begin
      logic [7:0] prev;
      int n;
      seg_code.delete();
      seg_len.delete();
      prev = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int s = 0; s < n; s++) begin
        prev = prev ^ 8'($urandom_range(1, 255));
        seg_code.push_back(prev);
        seg_len.push_back($urandom_range(1, 31));
      end
      do_record();
      play_and_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
